four_input_rr_arbiter: RTL and testbench
========================================

# four_input_rr_arbiter

Four-requester round-robin arbiter that shares a single downstream resource, such as the 4-input OR/reduction datapath, between four clients. Each client raises a request and receives a registered one-hot grant. A client keeps its grant until it releases, or until a hold-limit timer preempts it when other clients are waiting. The block sits between the requesting masters and the shared datapath and also exports the combinational "any request" OR of the four request lines.

## Interface
- MAX_HOLD, 8: maximum consecutive granted cycles while another request is pending; 0 disables preemption
- CNT_W, $clog2(MAX_HOLD+1) (min 1): hold-counter width
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk
- req  in  4  request per client; bit i = client i
- done  in  4  release strobe per client; only the bit of the current grantee is honoured
- gnt  out  4  registered one-hot grant; all-zero when idle
- gnt_id  out  2  registered binary index of the grantee; valid only when gnt_valid=1
- gnt_valid  out  1  registered; equals |gnt
- any_req  out  1  combinational OR of req[3:0]
- preempt  out  1  registered one-cycle pulse when a grant is ended by the hold timer

## Operation
- State machine: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, … mod 4.
  - Load gnt, gnt_id, cnt=1, and move to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT, release condition: done[gnt_id]=1 or req[gnt_id]=0. On release:
  - Go to IDLE, clear gnt, set ptr=gnt_id+1 (mod 4), cnt=0.
- GRANT, preemption condition: MAX_HOLD != 0, cnt==MAX_HOLD, no release, and (req & ~gnt) != 0. On preemption:
  - Same actions as a release, plus preempt=1 for one cycle.
- GRANT, otherwise:
  - Stay in GRANT.
  - cnt increments, saturating at MAX_HOLD.
  - At saturation with no other requester pending, the grant simply continues; preemption fires on the first cycle any other request appears.
- Release has priority over preemption in the same cycle; preempt stays 0.
- done bits of non-grantees are ignored. done is also ignored in IDLE.
- A request is never lost. A requester that keeps req high is granted within 3 arbitration rounds.
- ptr is a 2-bit register. Wrap-around 3→0 is inherent.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
  - ptr=0, cnt=0, state=IDLE.
- Reset mid-grant drops gnt at that same edge.
- Grant latency: req sampled high in IDLE at edge t → gnt valid after edge t (visible in cycle t+1).
- Release latency: done/req-drop sampled at edge t → gnt=0 in cycle t+1.
- Every grant is followed by exactly one IDLE cycle, so back-to-back grants are separated by one gnt=0 cycle. Next grant is visible at cycle t+2.
- Hold: a grantee with others waiting holds gnt for exactly MAX_HOLD cycles. preempt is high in the first gnt=0 cycle.
- any_req has zero latency (purely combinational).

## Structure
- Shared package four_arb_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Client count constant N_CLIENT=4.
- One sub-module: rr_pick4. It is combinational, takes (req[3:0], ptr[1:0]) and returns (hit, idx[1:0], onehot[3:0]). It is instantiated once in the IDLE decode.
- Top level holds the FSM, ptr, cnt and output registers.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, req=0 → gnt=0, gnt_valid=0, preempt=0, any_req=0.
- Single request: req=4'b0100 at cycle 5 → gnt=4'b0100, gnt_id=2 at cycle 6. done[2] pulse at cycle 9 → gnt=0 at cycle 10, and ptr=3 afterwards.
- Round-robin fairness: req=4'b1111 held, each grantee pulses done on its second granted cycle → grant order 0,1,2,3,0. Each grant is separated by one gnt=0 cycle.
- Preemption: MAX_HOLD=8, req=4'b0011 held, no done → client 0 is granted for exactly 8 cycles, then preempt=1 with gnt=0, then client 1 is granted. No preempt when only req=4'b0001 is held for 20 cycles.
- Simultaneous release and timeout: done[gnt_id] asserted on the cycle cnt==MAX_HOLD with other requests pending → gnt=0 next cycle, preempt=0.
- Reset mid-grant plus ignored done: client 3 granted, done=4'b0001 pulsed → gnt unchanged. rst_n=0 pulsed → gnt=0 next cycle. With req=4'b1000 still high, client 3 is re-granted from ptr=0 one cycle after reset deasserts.

Source files
------------

// File: rtl/four_arb_pkg.sv
// Shared constants and types for the four-input round-robin arbiter.
// Imported by the interface, the picker and the top level.
package four_arb_pkg;

  localparam int N_CLIENT = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } arb_state_e;

  // The pointer wraps 3 -> 0 through the natural 2-bit overflow.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/four_input_rr_arbiter_if.sv
// Client-side bundle of the arbiter: requests and releases in, grant status out.
// The master modport is the requesting side, the slave modport is the arbiter.
interface four_input_rr_arbiter_if;
  import four_arb_pkg::*;

  logic [N_CLIENT-1:0] req;
  logic [N_CLIENT-1:0] done;
  logic [N_CLIENT-1:0] gnt;
  logic [1:0]          gnt_id;
  logic                gnt_valid;
  logic                any_req;
  logic                preempt;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  any_req,
    input  preempt
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output any_req,
    output preempt
  );

endinterface

// File: rtl/four_input_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upward, modulo four. Returns hit, binary index and one-hot grant.
module rr_pick4
  import four_arb_pkg::*;
(
  input  logic [N_CLIENT-1:0] req,
  input  logic [1:0]          ptr,
  output logic                hit,
  output logic [1:0]          idx,
  output logic [N_CLIENT-1:0] onehot
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the closest candidate to ptr wins.
  always_comb begin
    hit    = 1'b0;
    idx    = 2'd0;
    onehot = '0;
    cand   = 2'd0;
    for (int k = N_CLIENT - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
    if (hit) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/four_input_rr_arbiter.sv
// Four-client round-robin arbiter with registered one-hot grant, release on
// done/req-drop, and an optional hold-limit timer that preempts long grants.
module four_input_rr_arbiter
  import four_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  four_input_rr_arbiter_if.slave  bus
);

  localparam logic             HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_e          state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CLIENT-1:0] gnt_q, gnt_d;
  logic [1:0]          gnt_id_q, gnt_id_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                preempt_q, preempt_d;

  logic                pick_hit;
  logic [1:0]          pick_idx;
  logic [N_CLIENT-1:0] pick_onehot;
  logic                release_now;
  logic                timeout_now;

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .hit    (pick_hit),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Only the current grantee's done/req bits matter; everything else is ignored.
  assign release_now = bus.done[gnt_id_q] | ~bus.req[gnt_id_q];
  assign timeout_now = HOLD_EN && (cnt_q == HOLD_MAX) && ((bus.req & ~gnt_q) != '0);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    preempt_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_hit) begin
          state_d  = GRANT;
          gnt_d    = pick_onehot;
          gnt_id_d = pick_idx;
          cnt_d    = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_now || timeout_now) begin
          // Release wins over timeout, so preempt only flags a pure timeout.
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = next_idx(gnt_id_q);
          cnt_d     = '0;
          preempt_d = ~release_now;
        end else if (HOLD_EN && (cnt_q != HOLD_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;
  assign bus.any_req   = |bus.req;

endmodule

// File: tb/tb_four_input_rr_arbiter.sv
// Directed bench for four_input_rr_arbiter: a vector table for reset, single
// request and round-robin order, then hand sequences for hold/preempt/reset.
module tb_four_input_rr_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int N_VEC    = 25;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  four_input_rr_arbiter_if bus();

  four_input_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
  } vec_t;

  vec_t vecs [N_VEC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next one.
  task automatic step(input logic r_n, input logic [3:0] r, input logic [3:0] d);
    rst_n    = r_n;
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g,
                            input logic [1:0] id, input logic pre);
    logic [3:0] any_exp;
    any_exp = {3'b0, |bus.req};
    check({tag, ".gnt"}, bus.gnt, g);
    check({tag, ".gnt_valid"}, {3'b0, bus.gnt_valid}, {3'b0, |g});
    if (g != 4'b0000) check({tag, ".gnt_id"}, {2'b0, bus.gnt_id}, {2'b0, id});
    check({tag, ".preempt"}, {3'b0, bus.preempt}, {3'b0, pre});
    check({tag, ".any_req"}, {3'b0, bus.any_req}, any_exp);
  endtask

  initial begin
    // {rstn, req, done, expected gnt, expected gnt_id, expected preempt}
    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0};
    vecs[3]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0};
    vecs[4]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0};
    vecs[5]  = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    // ptr is now 3, so {3,0} requesting picks client 3.
    vecs[7]  = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0};
    vecs[8]  = '{1'b1, 4'b1001, 4'b1000, 4'b0000, 2'd0, 1'b0};
    // Round robin from ptr=0, each client releases on its second granted cycle.
    vecs[9]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0};
    vecs[12] = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0};
    vecs[13] = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0};
    vecs[14] = '{1'b1, 4'b1111, 4'b0010, 4'b0000, 2'd0, 1'b0};
    vecs[15] = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0};
    vecs[16] = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0};
    vecs[17] = '{1'b1, 4'b1111, 4'b0100, 4'b0000, 2'd0, 1'b0};
    vecs[18] = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0};
    vecs[19] = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0};
    vecs[20] = '{1'b1, 4'b1111, 4'b1000, 4'b0000, 2'd0, 1'b0};
    vecs[21] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0};
    vecs[22] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0};
    vecs[23] = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0};
    vecs[24] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    @(posedge clk);
    #1;

    for (int i = 0; i < N_VEC; i++) begin
      step(vecs[i].rstn, vecs[i].req, vecs[i].done);
      expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].pre);
    end

    // Preemption: client 0 holds exactly MAX_HOLD cycles while client 1 waits.
    step(1'b0, 4'b0000, 4'b0000);
    expect_out("pre_reset", 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(1'b1, 4'b0011, 4'b0000);
      expect_out($sformatf("hold_c0_%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    step(1'b1, 4'b0011, 4'b0000);
    expect_out("preempt_c0", 4'b0000, 2'd0, 1'b1);
    step(1'b1, 4'b0011, 4'b0000);
    expect_out("grant_c1", 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000);
    expect_out("release_c1", 4'b0000, 2'd0, 1'b0);

    // Lone requester past saturation: no preemption until someone else asks.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b0001, 4'b0000);
      expect_out($sformatf("solo_c0_%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    step(1'b1, 4'b0011, 4'b0000);
    expect_out("late_preempt", 4'b0000, 2'd0, 1'b1);
    step(1'b1, 4'b0000, 4'b0000);
    expect_out("idle_after_late", 4'b0000, 2'd0, 1'b0);

    // Release on the same cycle as the timeout: release wins, no preempt.
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(1'b1, 4'b0011, 4'b0000);
      expect_out($sformatf("hold_c1_%0d", i), 4'b0010, 2'd1, 1'b0);
    end
    step(1'b1, 4'b0011, 4'b0010);
    expect_out("release_at_limit", 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b0011, 4'b0000);
    expect_out("after_release_c0", 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000);
    expect_out("idle_again", 4'b0000, 2'd0, 1'b0);

    // Reset mid-grant, with a foreign done bit that must be ignored.
    step(1'b0, 4'b0000, 4'b0000);
    expect_out("rst_before_c3", 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b1000, 4'b0000);
    expect_out("grant_c3", 4'b1000, 2'd3, 1'b0);
    step(1'b1, 4'b1000, 4'b0001);
    expect_out("foreign_done", 4'b1000, 2'd3, 1'b0);
    step(1'b0, 4'b1000, 4'b0000);
    expect_out("rst_mid_grant", 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b1000, 4'b0000);
    expect_out("regrant_c3", 4'b1000, 2'd3, 1'b0);
    step(1'b1, 4'b0000, 4'b0000);
    expect_out("final_idle", 4'b0000, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
